move_requester: RTL and testbench
=================================

# move_requester

Input-side initiator for the movement handshake. It conditions the four raw push-buttons by synchronising, debouncing, edge-detecting and auto-repeating them. It merges the button events with gravity ticks from the game timer. It issues one movement request at a time to the board-memory responder and holds each request until the responder commits, declines or steals it. It sits between the button pins and the game timer on one side and the board memory on the other.

## Interface
- DEBOUNCE_CYCLES, 250000: cycles a synchronised button level must stay stable before it is accepted (about 10 ms at 25.175 MHz).
- REPEAT_DELAY, 5000000: cycles a held L/R/D button must stay down before the first auto-repeat.
- REPEAT_PERIOD, 2000000: cycles between subsequent auto-repeats.
- RESP_TIMEOUT, 1024: maximum cycles a request may wait for a response.
- clk  in  1  single system clock (25.175 MHz pixel clock).
- reset  in  1  asynchronous, active-low reset.
- buttL, buttT, buttR, buttD  in  1 each  raw active-high buttons: left, rotate, right, soft-drop.
- gametick  in  1  one-cycle gravity pulse.
- move_req  out  1  request valid.
- move_code  out  3  request code: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DROP, 5 GRAVITY, 0 when idle.
- move_commit, move_declined, move_steal  in  1 each  one-cycle responder replies.
- gravity_blocked  out  1  one-cycle pulse when a GRAVITY request is declined (piece lands).
- missed_ticks  out  8  saturating count of gravity ticks lost while GRAVITY was already pending.
- timeout_err  out  1  sticky; set on response timeout.

## Operation
- Per button: 2-flop synchroniser, then a debounce counter that reloads on any level change. The debounced level updates when the counter reaches DEBOUNCE_CYCLES-1.
- A debounced rising edge sets the pending flag for that source.
- Auto-repeat applies to L, R and D only, never T. While a button is held, the repeat counter re-sets its pending flag after REPEAT_DELAY, then every REPEAT_PERIOD. Release clears the repeat counter.
- L and R both debounced-high: neither flag is set, and the existing L/R pending flags are cleared.
- gametick sets pend_grav. If pend_grav is already set, missed_ticks increments, saturating at 255.
- Arbitration priority: GRAVITY > ROTATE > LEFT > RIGHT > DROP. Granting a source clears its flag in the same cycle.
- FSM states:
  - IDLE: enter REQ when any flag is pending; latch the code.
  - REQ: move_req=1 and move_code stable.
    - commit → IDLE.
    - declined → IDLE; pulse gravity_blocked if the code was 5.
    - steal → IDLE and re-set the pending flag of the latched code.
    - timer reaches RESP_TIMEOUT → set timeout_err, → IDLE, drop the request.
- More than one response asserted in one cycle: the priority is commit > declined > steal.
- A response seen in IDLE is ignored.
- Reset: all flags, counters and FSM state clear; the debounced levels clear to 0. Outputs reset to move_req=0, move_code=0, gravity_blocked=0, missed_ticks=0, timeout_err=0.
- Reset asserted mid-request drops the request with no response needed.

## Timing
- Button-stable-to-move_req latency: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge/pending) + 1 (grant) cycles.
- gametick to move_req: 2 cycles when idle with nothing pending.
- A response in cycle n: move_req is low in n+1. A new request can start in n+2 at the earliest.
- All outputs are registered.
- The timeout counter starts at 0 on REQ entry and increments each REQ cycle.

## Structure
- Shared package holds the move_code constants (MV_NONE..MV_GRAVITY) and the FSM state encoding.
- Sub-module button_conditioner holds the synchroniser, debounce and repeat logic. There are four instances; T is instanced with repeat disabled.
- Arbiter and FSM live in the top of this block.

## Test plan
- Test parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- buttL bounces 1-0-1 within 3 cycles, then holds high → exactly one LEFT request, 8 cycles after the last edge. Auto-repeat requests follow at +20 and every 8 cycles while held.
- buttR and buttL held together, plus gametick → only GRAVITY is issued. Release L → RIGHT is issued.
- Request is GRAVITY and move_steal pulses → move_req falls, then GRAVITY is reissued 2 cycles later.
- GRAVITY request answered with move_declined → gravity_blocked pulses for 1 cycle.
- gametick pulses 3 times while GRAVITY is pending and unanswered → missed_ticks=3. After 300 total such ticks → missed_ticks=255.
- No response for RESP_TIMEOUT cycles → timeout_err=1 (sticky) and move_req=0. Reset mid-REQ → all outputs 0 on the next edge.

Source files
------------

// File: rtl/move_requester_pkg.sv
// Shared move codes, FSM state encoding and pending-flag helpers for the
// movement-request initiator.
package move_requester_pkg;

  localparam logic [2:0] MV_NONE    = 3'd0;
  localparam logic [2:0] MV_LEFT    = 3'd1;
  localparam logic [2:0] MV_RIGHT   = 3'd2;
  localparam logic [2:0] MV_ROTATE  = 3'd3;
  localparam logic [2:0] MV_DROP    = 3'd4;
  localparam logic [2:0] MV_GRAVITY = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic grav;
    logic rot;
    logic left;
    logic right;
    logic drop;
  } pend_t;

  // Fixed priority: GRAVITY > ROTATE > LEFT > RIGHT > DROP.
  function automatic logic [2:0] arb_pick(input pend_t p);
    logic [2:0] code;
    code = MV_NONE;
    if (p.grav)       code = MV_GRAVITY;
    else if (p.rot)   code = MV_ROTATE;
    else if (p.left)  code = MV_LEFT;
    else if (p.right) code = MV_RIGHT;
    else if (p.drop)  code = MV_DROP;
    return code;
  endfunction

  function automatic pend_t pend_write(input pend_t p, input logic [2:0] code,
                                       input logic val);
    pend_t r;
    r = p;
    case (code)
      MV_GRAVITY: r.grav  = val;
      MV_ROTATE:  r.rot   = val;
      MV_LEFT:    r.left  = val;
      MV_RIGHT:   r.right = val;
      MV_DROP:    r.drop  = val;
      default:    r = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/move_requester_button_conditioner.sv
// One push-button path: 2-flop synchroniser, reload-on-change debounce,
// rising-edge detect and optional hold-to-repeat.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 2000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic butt_i,
  output logic level_o,
  output logic press_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LOAD    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD = RW'(REPEAT_PERIOD - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d, deb_d1_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rise, rpt_fire;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; a bounce back to the accepted level reloads it.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == deb_q) begin
      db_cnt_d = DB_LOAD;
    end else if (db_cnt_q == '0) begin
      deb_d    = sync2_q;
      db_cnt_d = DB_LOAD;
    end else begin
      db_cnt_d = db_cnt_q - 1'b1;
    end
  end

  assign rise     = deb_q & ~deb_d1_q;
  assign rpt_fire = REPEAT_EN && deb_q && deb_d1_q && (rpt_cnt_q == '0);

  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    if (!REPEAT_EN || !deb_q) begin
      rpt_cnt_d = '0;
    end else if (rise) begin
      rpt_cnt_d = RPT_DELAY;
    end else if (rpt_cnt_q == '0) begin
      rpt_cnt_d = RPT_PERIOD;
    end else begin
      rpt_cnt_d = rpt_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_d1_q  <= 1'b0;
      db_cnt_q  <= DB_LOAD;
      rpt_cnt_q <= '0;
    end else begin
      sync1_q   <= butt_i;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_d1_q  <= deb_q;
      db_cnt_q  <= db_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign level_o = deb_q;
  assign press_o = rise | rpt_fire;

endmodule

// File: rtl/move_requester.sv
// Movement-request initiator: conditions the four buttons, merges them with
// gravity ticks, and holds one request at a time until the responder replies.
//
// state  | meaning
// S_IDLE | no request outstanding; grant highest pending source
// S_REQ  | move_req high, waiting for commit / declined / steal / timeout
module move_requester
  import move_requester_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 2000000,
  parameter int RESP_TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buttL,
  input  logic       buttT,
  input  logic       buttR,
  input  logic       buttD,
  input  logic       gametick,
  output logic       move_req,
  output logic [2:0] move_code,
  input  logic       move_commit,
  input  logic       move_declined,
  input  logic       move_steal,
  output logic       gravity_blocked,
  output logic [7:0] missed_ticks,
  output logic       timeout_err
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LIMIT = TW'(RESP_TIMEOUT);

  logic lvl_l, lvl_t, lvl_r, lvl_d;
  logic ev_l, ev_t, ev_r, ev_d;
  logic unused_lvl;

  state_e        state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [TW-1:0] tmr_q, tmr_d;
  pend_t         pend_q, pend_d;
  logic          req_q, req_d;
  logic [2:0]    mcode_q, mcode_d;
  logic          blocked_q, blocked_d;
  logic [7:0]    missed_q, missed_d;
  logic          terr_q, terr_d;
  logic          grant_grav;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
  ) u_cond_l (
    .clk(clk), .reset(reset), .butt_i(buttL), .level_o(lvl_l), .press_o(ev_l)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
  ) u_cond_t (
    .clk(clk), .reset(reset), .butt_i(buttT), .level_o(lvl_t), .press_o(ev_t)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
  ) u_cond_r (
    .clk(clk), .reset(reset), .butt_i(buttR), .level_o(lvl_r), .press_o(ev_r)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
  ) u_cond_d (
    .clk(clk), .reset(reset), .butt_i(buttD), .level_o(lvl_d), .press_o(ev_d)
  );

  assign unused_lvl = lvl_t ^ lvl_d;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    tmr_d      = tmr_q;
    pend_d     = pend_q;
    blocked_d  = 1'b0;
    missed_d   = missed_q;
    terr_d     = terr_q;
    grant_grav = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          code_d     = arb_pick(pend_q);
          pend_d     = pend_write(pend_q, code_d, 1'b0);
          grant_grav = (code_d == MV_GRAVITY);
          tmr_d      = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        tmr_d = tmr_q + 1'b1;
        if (move_commit) begin
          state_d = S_IDLE;
        end else if (move_declined) begin
          state_d   = S_IDLE;
          blocked_d = (code_q == MV_GRAVITY);
        end else if (move_steal) begin
          state_d = S_IDLE;
          pend_d  = pend_write(pend_q, code_q, 1'b1);
        end else if (tmr_d == TMR_LIMIT) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // New events are applied after the grant so a same-cycle press is kept.
    if (ev_t) pend_d.rot  = 1'b1;
    if (ev_d) pend_d.drop = 1'b1;
    if (lvl_l && lvl_r) begin
      pend_d.left  = 1'b0;
      pend_d.right = 1'b0;
    end else begin
      if (ev_l) pend_d.left  = 1'b1;
      if (ev_r) pend_d.right = 1'b1;
    end

    if (gametick) begin
      if (pend_q.grav && !grant_grav && (missed_q != 8'hFF)) begin
        missed_d = missed_q + 8'd1;
      end
      pend_d.grav = 1'b1;
    end

    req_d   = (state_d == S_REQ);
    mcode_d = (state_d == S_REQ) ? code_d : MV_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      code_q    <= MV_NONE;
      tmr_q     <= '0;
      pend_q    <= '0;
      req_q     <= 1'b0;
      mcode_q   <= MV_NONE;
      blocked_q <= 1'b0;
      missed_q  <= 8'd0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      tmr_q     <= tmr_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      mcode_q   <= mcode_d;
      blocked_q <= blocked_d;
      missed_q  <= missed_d;
      terr_q    <= terr_d;
    end
  end

  assign move_req        = req_q;
  assign move_code       = mcode_q;
  assign gravity_blocked = blocked_q;
  assign missed_ticks    = missed_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_move_requester.sv
// Directed bench for move_requester with short debounce/repeat parameters.
module tb_move_requester;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;
  localparam int RTO  = 1024;

  localparam logic [2:0] C_LEFT = 3'd1, C_RIGHT = 3'd2, C_ROT = 3'd3, C_GRAV = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic       buttL, buttT, buttR, buttD, gametick;
  logic       move_req;
  logic [2:0] move_code;
  logic       move_commit, move_declined, move_steal;
  logic       gravity_blocked;
  logic [7:0] missed_ticks;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  move_requester #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER), .RESP_TIMEOUT(RTO)
  ) dut (
    .clk(clk), .reset(reset),
    .buttL(buttL), .buttT(buttT), .buttR(buttR), .buttD(buttD),
    .gametick(gametick),
    .move_req(move_req), .move_code(move_code),
    .move_commit(move_commit), .move_declined(move_declined), .move_steal(move_steal),
    .gravity_blocked(gravity_blocked), .missed_ticks(missed_ticks), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns the number of falling edges waited until move_req is seen, or -1.
  task automatic wait_req(input int max_cyc, output int n);
    n = 0;
    while (move_req !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (move_req !== 1'b1) n = -1;
  endtask

  task automatic pulse_resp(input logic c, input logic d, input logic s);
    move_commit = c; move_declined = d; move_steal = s;
    @(negedge clk);
    move_commit = 1'b0; move_declined = 1'b0; move_steal = 1'b0;
  endtask

  task automatic tick_and_wait(output int n);
    gametick = 1'b1;
    @(negedge clk);
    gametick = 1'b0;
    wait_req(10, n);
  endtask

  task automatic drain(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      move_commit = move_req;
      @(negedge clk);
    end
    move_commit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    buttL = 0; buttT = 0; buttR = 0; buttD = 0; gametick = 0;
    move_commit = 0; move_declined = 0; move_steal = 0;
    repeat (3) @(negedge clk);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0d want 0", move_req); end
    checks++; if (move_code !== 3'd0) begin errors++; $display("FAIL rst_code: got %0d want 0", move_code); end
    checks++; if (gravity_blocked !== 1'b0 || timeout_err !== 1'b0 || missed_ticks !== 8'd0) begin
      errors++; $display("FAIL rst_misc: blk=%0d terr=%0d missed=%0d want 0/0/0", gravity_blocked, timeout_err, missed_ticks);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL post_rst_req: got %0d want 0", move_req); end
  endtask

  task automatic test_bounce_repeat();
    int n, t0;
    buttL = 1'b1; @(negedge clk);
    buttL = 1'b0; @(negedge clk);
    buttL = 1'b1;
    wait_req(30, n);
    checks++; if (n != 8) begin errors++; $display("FAIL bounce_latency: got %0d want 8", n); end
    checks++; if (move_code !== C_LEFT) begin errors++; $display("FAIL bounce_code: got %0d want %0d", move_code, C_LEFT); end
    t0 = cyc;
    pulse_resp(1'b1, 1'b0, 1'b0);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL commit_drop: got %0d want 0", move_req); end
    wait_req(40, n);
    checks++; if (cyc - t0 != RDLY) begin errors++; $display("FAIL repeat_delay: got %0d want %0d", cyc - t0, RDLY); end
    checks++; if (move_code !== C_LEFT) begin errors++; $display("FAIL repeat1_code: got %0d want %0d", move_code, C_LEFT); end
    t0 = cyc;
    pulse_resp(1'b1, 1'b0, 1'b0);
    wait_req(20, n);
    checks++; if (cyc - t0 != RPER) begin errors++; $display("FAIL repeat_period: got %0d want %0d", cyc - t0, RPER); end
    t0 = cyc;
    pulse_resp(1'b1, 1'b0, 1'b0);
    wait_req(20, n);
    checks++; if (cyc - t0 != RPER) begin errors++; $display("FAIL repeat_period2: got %0d want %0d", cyc - t0, RPER); end
    buttL = 1'b0;
    drain(40);
  endtask

  task automatic test_lr_conflict();
    int n, t0;
    logic seen;
    buttL = 1'b1; buttR = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (move_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL lr_none: got req=%0d want 0", seen); end
    t0 = cyc;
    tick_and_wait(n);
    checks++; if (cyc - t0 != 2) begin errors++; $display("FAIL tick_latency: got %0d want 2", cyc - t0); end
    checks++; if (move_code !== C_GRAV) begin errors++; $display("FAIL lr_grav_code: got %0d want %0d", move_code, C_GRAV); end
    pulse_resp(1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (move_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL lr_none_after_grav: got req=%0d want 0", seen); end
    buttL = 1'b0;
    wait_req(60, n);
    checks++; if (move_req !== 1'b1 || move_code !== C_RIGHT) begin
      errors++; $display("FAIL lr_right: got req=%0d code=%0d want 1/%0d", move_req, move_code, C_RIGHT);
    end
    pulse_resp(1'b1, 1'b0, 1'b0);
    buttR = 1'b0;
    drain(40);
  endtask

  task automatic test_steal();
    int n;
    logic seen;
    tick_and_wait(n);
    pulse_resp(1'b0, 1'b0, 1'b1);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL steal_drop: got %0d want 0", move_req); end
    @(negedge clk);
    checks++; if (move_req !== 1'b1 || move_code !== C_GRAV) begin
      errors++; $display("FAIL steal_reissue: got req=%0d code=%0d want 1/%0d", move_req, move_code, C_GRAV);
    end
    pulse_resp(1'b1, 1'b0, 1'b1);
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (move_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL commit_over_steal: got req=%0d want 0", seen); end
    pulse_resp(1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (move_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL idle_steal_ignored: got req=%0d want 0", seen); end
  endtask

  task automatic test_declined();
    int n;
    logic seen;
    tick_and_wait(n);
    pulse_resp(1'b0, 1'b1, 1'b0);
    checks++; if (gravity_blocked !== 1'b1 || move_req !== 1'b0) begin
      errors++; $display("FAIL decl_blocked: got blk=%0d req=%0d want 1/0", gravity_blocked, move_req);
    end
    @(negedge clk);
    checks++; if (gravity_blocked !== 1'b0) begin errors++; $display("FAIL decl_pulse_width: got %0d want 0", gravity_blocked); end
    buttT = 1'b1;
    wait_req(20, n);
    checks++; if (move_code !== C_ROT) begin errors++; $display("FAIL rot_code: got %0d want %0d", move_code, C_ROT); end
    pulse_resp(1'b0, 1'b1, 1'b0);
    checks++; if (gravity_blocked !== 1'b0) begin errors++; $display("FAIL rot_decl_blocked: got %0d want 0", gravity_blocked); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (move_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rot_no_repeat: got req=%0d want 0", seen); end
    buttT = 1'b0;
    drain(20);
  endtask

  task automatic test_missed_timeout();
    int n, t0;
    checks++; if (missed_ticks !== 8'd0) begin errors++; $display("FAIL missed_init: got %0d want 0", missed_ticks); end
    tick_and_wait(n);
    gametick = 1'b1;
    repeat (4) @(negedge clk);
    gametick = 1'b0;
    checks++; if (missed_ticks !== 8'd3) begin errors++; $display("FAIL missed_3: got %0d want 3", missed_ticks); end
    gametick = 1'b1;
    repeat (251) @(negedge clk);
    gametick = 1'b0;
    checks++; if (missed_ticks !== 8'd254) begin errors++; $display("FAIL missed_254: got %0d want 254", missed_ticks); end
    gametick = 1'b1;
    repeat (45) @(negedge clk);
    gametick = 1'b0;
    checks++; if (missed_ticks !== 8'd255) begin errors++; $display("FAIL missed_sat: got %0d want 255", missed_ticks); end
    checks++; if (move_req !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL still_pending: got req=%0d terr=%0d want 1/0", move_req, timeout_err);
    end
    pulse_resp(1'b1, 1'b0, 1'b0);
    wait_req(5, n);
    t0 = cyc;
    while (move_req === 1'b1 && cyc - t0 < RTO + 100) @(negedge clk);
    checks++; if (cyc - t0 != RTO) begin errors++; $display("FAIL timeout_len: got %0d want %0d", cyc - t0, RTO); end
    checks++; if (timeout_err !== 1'b1 || move_req !== 1'b0) begin
      errors++; $display("FAIL timeout_flag: got terr=%0d req=%0d want 1/0", timeout_err, move_req);
    end
    tick_and_wait(n);
    pulse_resp(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0d want 1", timeout_err); end
  endtask

  task automatic test_reset_mid_req();
    int n;
    logic seen;
    tick_and_wait(n);
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL midreq_setup: got %0d want 1", move_req); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (move_req !== 1'b0 || move_code !== 3'd0 || gravity_blocked !== 1'b0 ||
                  missed_ticks !== 8'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL midreq_reset: got req=%0d code=%0d blk=%0d missed=%0d terr=%0d want all 0",
                         move_req, move_code, gravity_blocked, missed_ticks, timeout_err);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (move_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreq_dropped: got req=%0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_bounce_repeat();
    test_lr_conflict();
    test_steal();
    test_declined();
    test_missed_timeout();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
